// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - bus bundle between the micro_sequencer and its datapath/loader
//
// Purpose: groups the opcode/flag inputs, the microcode write port and the
// control-word outputs of micro_sequencer.
// Modports:
//   slave  - the sequencer: receives opcode_in, flags_in, cont, ucode_*,
//            drives ctrl_out, step_out, instr_done, halted
//   master - the datapath/loader side, directions reversed
interface micro_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CW_W     = 17,
  parameter int FLAG_W   = 2
);
  logic [OPCODE_W-1:0]        opcode_in;
  logic [FLAG_W-1:0]          flags_in;
  logic                       cont;
  logic                       ucode_we;
  logic [OPCODE_W+STEP_W-1:0] ucode_addr;
  logic [CW_W+3:0]            ucode_wdata;
  logic [CW_W-1:0]            ctrl_out;
  logic [STEP_W-1:0]          step_out;
  logic                       instr_done;
  logic                       halted;

  modport slave (
    input  opcode_in, flags_in, cont, ucode_we, ucode_addr, ucode_wdata,
    output ctrl_out, step_out, instr_done, halted
  );

  modport master (
    output opcode_in, flags_in, cont, ucode_we, ucode_addr, ucode_wdata,
    input  ctrl_out, step_out, instr_done, halted
  );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogrammed control sequencer with writable microcode store
//
// Purpose: every cycle drives the control word stored at {opcode_in, step}.
// Instructions end early on the word's end bit, on a halt word, on step
// wrap, or (when MICRO_COND_END_EN is defined) when the flag selected by the
// word's cond field is 0. A halt word parks the sequencer in HALTED until
// cont is sampled high.
// Optional feature macro: MICRO_COND_END_EN (flag-conditional early end).
// Ports:
//   clk  - system clock, all state on the rising edge
//   rstn - asynchronous reset, active HIGH despite the name
//   bus  - micro_sequencer_if.slave: opcode_in, flags_in, cont, ucode_we,
//          ucode_addr, ucode_wdata in; ctrl_out, step_out, instr_done,
//          halted out
// Microword layout: {halt, end, cond[1:0], ctrl[CW_W-1:0]}.
module micro_sequencer #(
  parameter int              OPCODE_W  = 4,
  parameter int              STEP_W    = 3,
  parameter int              CW_W      = 17,
  parameter logic [CW_W-1:0] CTRL_IDLE = 17'h1FE7F,
  parameter int              FLAG_W    = 2
) (
  input logic               clk,
  input logic               rstn,
  micro_sequencer_if.slave  bus
);

  localparam int AW    = OPCODE_W + STEP_W;
  localparam int WW    = CW_W + 4;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic                halted_q;

  logic [WW-1:0]       store [DEPTH];
  logic [WW-1:0]       word;
  logic                w_halt;
  logic                w_end;
  logic [1:0]          w_cond;
  logic                cond_eoi;
  logic                eoi;

  // Store is deliberately not reset so microcode survives a reset.
  always_ff @(posedge clk) begin
    if (bus.ucode_we) begin
      store[bus.ucode_addr] <= bus.ucode_wdata;
    end
  end

  // Combinational read: a write to the addressed word shows up next cycle.
  assign word   = store[{bus.opcode_in, step}];
  assign w_halt = word[CW_W+3];
  assign w_end  = word[CW_W+2];
  assign w_cond = word[CW_W+1:CW_W];

`ifdef MICRO_COND_END_EN
  // cond=k selects flags_in[k-1]; a clear flag ends the instruction.
  // Selects beyond the flag vector never match and so never terminate.
  always_comb begin
    cond_eoi = 1'b0;
    for (int i = 0; i < FLAG_W; i++) begin
      if ((int'(w_cond) == i + 1) && !bus.flags_in[i]) begin
        cond_eoi = 1'b1;
      end
    end
  end
`else
  logic unused_cond;
  assign unused_cond = ^{w_cond, bus.flags_in};
  assign cond_eoi    = 1'b0;
`endif

  assign eoi = w_end | w_halt | (step == {STEP_W{1'b1}}) | cond_eoi;

  // Outputs see reset combinationally so strobes go idle the moment it hits.
  assign bus.ctrl_out   = (rstn || state == HALTED) ? CTRL_IDLE : word[CW_W-1:0];
  assign bus.instr_done = rstn ? w_end : (state == RUN) && eoi;
  assign bus.step_out   = step;
  assign bus.halted     = halted_q;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= RUN;
      step     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (w_halt) begin
            // halt wins over end; the halt word itself was driven this cycle
            state    <= HALTED;
            step     <= '0;
            halted_q <= 1'b1;
          end else if (eoi) begin
            step <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        HALTED: begin
          step <= '0;
          if (bus.cont) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          step     <= '0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogrammed control sequencer: the next-generation control unit for the 8-bit bus machine. It replaces the fixed-width, fixed-step control logic. Each cycle it drives one control word, read from a writable microcode store addressed by {opcode, step}. It adds variable-length instructions (early end), a halt/continue state, and optional flag-conditional early termination for conditional jumps. It sits between the instruction register opcode field and every load/enable/inc/clr strobe on the datapath.

## Interface
Parameters:
- OPCODE_W, 4: opcode width (instruction register upper nibble).
- STEP_W, 3: step counter width; at most 2^STEP_W steps per instruction.
- CW_W, 17: control word width driven onto the datapath strobes.
- CTRL_IDLE, 17'h1FE7F (width CW_W): control word driven in reset/HALTED, all strobes inactive; active-low strobes idle at 1.
- FLAG_W, 2: flag input width (bit0 carry, bit1 zero).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  asynchronous, active-high reset.
- opcode_in  in  OPCODE_W  current opcode from the instruction register.
- flags_in  in  FLAG_W  ALU flags.
- cont  in  1  leaves HALTED when sampled high.
- ucode_we  in  1  microcode write strobe.
- ucode_addr  in  OPCODE_W+STEP_W  write address {opcode, step}.
- ucode_wdata  in  CW_W+4  microword {halt, end, cond[1:0], ctrl[CW_W-1:0]}.
- ctrl_out  out  CW_W  control word for the current step.
- step_out  out  STEP_W  current step number.
- instr_done  out  1  high during the final step of an instruction.
- halted  out  1  high in HALTED.

## Operation
- Store: 2^(OPCODE_W+STEP_W) words of CW_W+4 bits. Not reset. Written on the rising edge when ucode_we=1. Read is combinational at {opcode_in, step}.
- States: RUN and HALTED. Reset enters RUN with step=0.
- RUN: ctrl_out = word.ctrl. End-of-instruction (eoi) is true when any of these holds:
  - word.end=1;
  - word.halt=1;
  - step = 2^STEP_W-1 (wrap);
  - conditional termination (see Configuration).
- On eoi: instr_done=1 and the next step is 0. Otherwise step increments.
- word.halt=1: ctrl_out drives this step's word; the next state is HALTED with step=0.
- HALTED: ctrl_out=CTRL_IDLE, step held at 0, halted=1, instr_done=0. cont=1 on a rising edge gives RUN with step=0 next cycle.
- Fetch steps are ordinary microcode: software duplicates them in every opcode's region. The sequencer has no fetch special case. opcode_in may change after the IR load and takes effect immediately in the address.
- Write to the currently addressed word: the read shows the old data this cycle and the new data from the next cycle.
- Reset values: step_out=0, halted=0, instr_done=word.end of address {opcode_in,0}, ctrl_out=CTRL_IDLE while rstn=1. Reset asserted mid-instruction aborts it immediately; outputs take reset values asynchronously.

## Timing
- Zero latency from address to ctrl_out, which is combinational. Step and state update one cycle later.
- An instruction of N steps (end=1 on step N-1) occupies exactly N cycles; the next instruction's step 0 follows without a bubble.
- halted rises the cycle after the halt step. After cont is sampled, step 0 is driven the following cycle.
- cont sampled in RUN is ignored.
- Simultaneous halt=1 and end=1 in one word: halt wins.

## Configuration
- MICRO_COND_END_EN defined:
  - cond≠0 selects flags_in[cond-1].
  - If the selected flag is 0, the step is treated as eoi: ctrl_out still drives that word; the remaining steps are skipped.
  - Out-of-range selects (cond-1 ≥ FLAG_W) never terminate.
- Not defined: cond bits are ignored; ctrl_out and step behaviour are otherwise identical.

## Test plan
- Reset: hold rstn=1 for 12 ns -> ctrl_out=CTRL_IDLE, step_out=0, halted=0. Release -> step 0 word of opcode_in driven next edge.
- Six-step ADD (opcode 4'h1, end=1 at step 5): ctrl_out sequences words 0x08..0x0D. instr_done=1 only at step 5. The next cycle shows step_out=0.
- Wrap: opcode 4'h3 with no end bit set -> eight steps 0..7, then step 0. instr_done=1 at step 7.
- Halt at step 3 of opcode 4'hF -> word 0x7B driven for one cycle; halted=1 and ctrl_out=CTRL_IDLE next. cont pulse -> step 0 two edges later.
- Conditional (MICRO_COND_END_EN), JC opcode 4'h7, cond=01 at step 3:
  - flags_in=2'b00 -> instruction ends at step 3 (4 cycles);
  - flags_in=2'b01 -> runs to end at step 4 (5 cycles).
  - Without the macro: 5 cycles in both cases.
- Mid-run: assert rstn at step 2 -> step_out=0 and ctrl_out=CTRL_IDLE asynchronously. Microcode written beforehand is retained and reads back unchanged.
